// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: single-port CPU bus slave that splits an 18-bit address
// space into synchronous RAM and a small IO page (UART RX/TX, free-running
// cycle counter with coherent snapshot, program stop). Reads return data one
// cycle after the access through a registered source select.
module cpu_bus_responder #(
   parameter int TX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [16:0] ram_a,
   output logic [7:0]  ram_wdata,
   output logic        ram_we,
   input  logic [7:0]  ram_rdata,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        program_done,
   output logic        tx_overflow
);

   localparam int AW = $clog2(TX_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(TX_DEPTH);
   localparam logic [CW-1:0] MARGIN_C   = CW'(FULL_MARGIN);
   localparam logic [17:0]   ADDR_UART  = 18'h30000;
   localparam logic [17:0]   ADDR_CLOCK = 18'h30004;

   // Which source drives mem_din in the cycle after a read
   typedef enum logic [1:0] {
      SRC_ZERO  = 2'd0,
      SRC_RAM   = 2'd1,
      SRC_UART  = 2'd2,
      SRC_CLOCK = 2'd3
   } src_e;

   src_e          src_q, src_d;
   logic [1:0]    byte_sel_q, byte_sel_d;
   logic [7:0]    uart_q, uart_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [31:0]   snap_q, snap_d;

   logic [7:0]    fifo_q [TX_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          stop_pending_q, stop_pending_d;
   logic          term_pending_q, term_pending_d;
   logic          term_pushed_q, term_pushed_d;
   logic          done_q, done_d;
   logic          overflow_q, overflow_d;

   logic          io_space_s;
   logic          uart_hit_s;
   logic          clock_hit_s;
   logic          stop_wr_s;
   logic          byte_wr_s;
   logic          pop_s;
   logic          full_s;
   logic          space_s;
   logic          term_req_s;
   logic          push_s;
   logic [7:0]    push_data_s;
   logic          unused_addr_s;

   // Address bits above 17 are not decoded
   assign unused_addr_s = ^mem_a[31:18];

   assign io_space_s  = (mem_a[17:16] == 2'b11);
   assign uart_hit_s  = (mem_a[17:0] == ADDR_UART);
   assign clock_hit_s = (mem_a[17:2] == ADDR_CLOCK[17:2]);
   assign stop_wr_s   = mem_wr && (mem_a[17:0] == ADDR_CLOCK);
   assign byte_wr_s   = mem_wr && uart_hit_s && (mem_dout != 8'h00);

   // RAM port is a straight pass-through; strobes are held off while in reset
   assign ram_a     = mem_a[16:0];
   assign ram_wdata = mem_dout;
   assign ram_we    = rst_in && mem_wr && !io_space_s;
   assign rx_pop    = rst_in && !mem_wr && uart_hit_s && rx_valid;

   // TX FIFO handshake. A full FIFO still accepts a push when a pop happens in
   // the same cycle. A pending terminator owns the push slot; a data byte
   // written in that same cycle loses and is reported as an overflow so that
   // no byte can overtake the terminator.
   assign tx_valid       = (count_q != {CW{1'b0}});
   assign tx_data        = fifo_q[rd_ptr_q];
   assign pop_s          = tx_valid && tx_ready;
   assign full_s         = (count_q == DEPTH_C);
   assign space_s        = !full_s || pop_s;
   assign term_req_s     = stop_wr_s || term_pending_q;
   assign push_s         = (term_req_s || byte_wr_s) && space_s;
   assign push_data_s    = term_req_s ? 8'h00 : mem_dout;
   assign io_buffer_full = ((DEPTH_C - count_q) <= MARGIN_C);
   assign program_done   = done_q;
   assign tx_overflow    = overflow_q;

   // Bus read path: pick the next-cycle data source and capture volatile data
   always_comb begin
      src_d      = SRC_ZERO;
      byte_sel_d = byte_sel_q;
      uart_d     = uart_q;
      snap_d     = snap_q;
      cnt_d      = cnt_q + 32'd1;
      if (!mem_wr) begin
         if (!io_space_s) begin
            src_d = SRC_RAM;
         end else if (uart_hit_s) begin
            src_d  = SRC_UART;
            uart_d = rx_valid ? rx_data : 8'h00;
         end else if (clock_hit_s) begin
            src_d      = SRC_CLOCK;
            byte_sel_d = mem_a[1:0];
            if (mem_a[1:0] == 2'b00) begin
               snap_d = cnt_q;
            end else begin
               snap_d = snap_q;
            end
         end else begin
            src_d = SRC_ZERO;
         end
      end else begin
         src_d = SRC_ZERO;
      end
   end

   // Read data mux driven from the registered source select
   always_comb begin
      mem_din = 8'h00;
      case (src_q)
         SRC_RAM:   mem_din = ram_rdata;
         SRC_UART:  mem_din = uart_q;
         SRC_CLOCK: begin
            case (byte_sel_q)
               2'd0:    mem_din = snap_q[7:0];
               2'd1:    mem_din = snap_q[15:8];
               2'd2:    mem_din = snap_q[23:16];
               2'd3:    mem_din = snap_q[31:24];
               default: mem_din = 8'h00;
            endcase
         end
         default:   mem_din = 8'h00;
      endcase
   end

   // TX FIFO bookkeeping, terminator hand-off and sticky status flags
   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      term_pending_d = term_pending_q;
      term_pushed_d  = term_pushed_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (term_req_s) begin
         term_pending_d = !space_s;
         term_pushed_d  = space_s;
      end else begin
         term_pending_d = term_pending_q;
         term_pushed_d  = term_pushed_q;
      end
      stop_pending_d = stop_pending_q || stop_wr_s;
      overflow_d     = overflow_q || (byte_wr_s && (term_req_s || !space_s));
      done_d         = done_q ||
                       (stop_pending_q && term_pushed_q && !term_pending_q && !tx_valid);
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk_in) begin
      if (push_s) begin
         fifo_q[wr_ptr_q] <= push_data_s;
      end
   end

   // State registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         src_q          <= SRC_ZERO;
         byte_sel_q     <= 2'd0;
         uart_q         <= 8'h00;
         cnt_q          <= 32'd0;
         snap_q         <= 32'd0;
         wr_ptr_q       <= {AW{1'b0}};
         rd_ptr_q       <= {AW{1'b0}};
         count_q        <= {CW{1'b0}};
         stop_pending_q <= 1'b0;
         term_pending_q <= 1'b0;
         term_pushed_q  <= 1'b0;
         done_q         <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         src_q          <= src_d;
         byte_sel_q     <= byte_sel_d;
         uart_q         <= uart_d;
         cnt_q          <= cnt_d;
         snap_q         <= snap_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         stop_pending_q <= stop_pending_d;
         term_pending_q <= term_pending_d;
         term_pushed_q  <= term_pushed_d;
         done_q         <= done_d;
         overflow_q     <= overflow_d;
      end
   end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Testbench for cpu_bus_responder: reset checks, a table of single-cycle bus
// accesses, hand-written multi-cycle sequences, then randomized traffic
// checked against a queue-based reference model.
module tb_cpu_bus_responder;

   localparam int TX_DEPTH    = 8;
   localparam int FULL_MARGIN = 2;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [16:0] ram_a;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [7:0]  ram_rdata;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        program_done;
   logic        tx_overflow;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   cpu_bus_responder #(.TX_DEPTH(TX_DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
      .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .ram_a(ram_a), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .program_done(program_done),
      .tx_overflow(tx_overflow)
   );

   // Synchronous RAM attached to the responder; unwritten locations read 0
   logic [7:0] env_ram [int];
   always @(posedge clk_in) begin
      ram_rdata <= env_ram.exists(int'(ram_a)) ? env_ram[int'(ram_a)] : 8'h00;
      if (ram_we) env_ram[int'(ram_a)] = ram_wdata;
   end

   // Watchdog
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   logic [7:0]  mq[$];
   logic [7:0]  txlog[$];
   logic [7:0]  ref_ram [int];
   bit          m_ovf, m_done, m_stop, m_tpend, m_tpushed;
   logic [31:0] m_cnt, m_snap;
   logic [7:0]  m_din;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 0; m_done = 0; m_stop = 0; m_tpend = 0; m_tpushed = 0;
      m_cnt = 32'd0; m_snap = 32'd0; m_din = 8'h00;
   endtask

   task automatic model_check();
      bit io;
      io = (mem_a[17:16] == 2'b11);
      chk("ram_we", 32'(ram_we), 32'(mem_wr && !io));
      chk("ram_a", 32'(ram_a), 32'(mem_a[16:0]));
      chk("rx_pop", 32'(rx_pop), 32'(!mem_wr && (mem_a[17:0] == 18'h30000) && rx_valid));
      chk("mem_din", 32'(mem_din), 32'(m_din));
      chk("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("tx_data", 32'(tx_data), 32'(mq[0]));
      chk("io_buffer_full", 32'(io_buffer_full), 32'((TX_DEPTH - mq.size()) <= FULL_MARGIN));
      chk("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
      chk("program_done", 32'(program_done), 32'(m_done));
   endtask

   // Advance the model by one clock using the inputs of the current cycle
   task automatic model_update();
      bit io, pop, space, stop_wr, byte_wr, new_done;
      logic [17:0] a18;
      int off;
      a18      = mem_a[17:0];
      io       = (a18[17:16] == 2'b11);
      pop      = (mq.size() > 0) && tx_ready;
      space    = (mq.size() < TX_DEPTH) || pop;
      stop_wr  = mem_wr && (a18 == 18'h30004);
      byte_wr  = mem_wr && (a18 == 18'h30000) && (mem_dout != 8'h00);
      new_done = m_done || (m_stop && m_tpushed && !m_tpend && mq.size() == 0);
      if (pop) void'(mq.pop_front());
      if (stop_wr || m_tpend) begin
         if (space) begin
            mq.push_back(8'h00); m_tpushed = 1; m_tpend = 0;
         end else begin
            m_tpend = 1; m_tpushed = 0;
         end
         if (byte_wr) m_ovf = 1;
      end else if (byte_wr) begin
         if (space) mq.push_back(mem_dout);
         else m_ovf = 1;
      end
      if (stop_wr) m_stop = 1;
      m_done = new_done;
      if (mem_wr) m_din = 8'h00;
      else if (!io) m_din = ref_ram.exists(int'(mem_a[16:0])) ? ref_ram[int'(mem_a[16:0])] : 8'h00;
      else if (a18 == 18'h30000) m_din = rx_valid ? rx_data : 8'h00;
      else if (a18[17:2] == 16'hC001) begin
         off = int'(a18[1:0]);
         if (off == 0) m_snap = m_cnt;
         m_din = 8'(m_snap >> (8 * off));
      end else m_din = 8'h00;
      if (mem_wr && !io) ref_ram[int'(mem_a[16:0])] = mem_dout;
      m_cnt = m_cnt + 32'd1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a = a; mem_wr = wr; mem_dout = d;
   endtask

   // Called at posedge+1 with inputs set; returns at the next posedge+1
   task automatic step(input bit use_model);
      #1;
      if (tx_valid && tx_ready) txlog.push_back(tx_data);
      if (use_model) model_check();
      model_update();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      drive(32'h0003_0008, 1'b0, 8'h00);
      rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      model_reset();
      txlog.delete();
   endtask

   typedef struct {
      logic [31:0] a;
      logic        wr;
      logic [7:0]  d;
      logic        rxv;
      logic [7:0]  rxd;
      logic        e_we;
      logic        e_pop;
      logic [7:0]  e_din;
      logic        e_txv;
   } vec_t;

   vec_t tv [13];

   initial begin
      bit got;
      logic [31:0] rnd;
      logic [15:0] lo;
      int r;

      tv[0]  = '{32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
      tv[1]  = '{32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
      tv[2]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h31, 1'b0, 1'b1, 8'hA5, 1'b0};
      tv[3]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h31, 1'b0, 1'b0, 8'h31, 1'b0};
      tv[4]  = '{32'h0003_0008, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
      tv[5]  = '{32'h0003_0010, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
      tv[6]  = '{32'h0002_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
      tv[7]  = '{32'h0001_2345, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0};
      tv[8]  = '{32'h0001_2345, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
      tv[9]  = '{32'h0000_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0};
      tv[10] = '{32'h0003_0000, 1'b1, 8'h00, 1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 1'b0};
      tv[11] = '{32'hABC0_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
      tv[12] = '{32'h0003_0008, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};

      // Reset state: strobes held off even with active-looking bus inputs
      rst_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      drive(32'h0000_0010, 1'b1, 8'h11);
      #2;
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      drive(32'h0003_0000, 1'b0, 8'h00);
      rx_valid = 1'b1; rx_data = 8'h55;
      #1;
      chk("rst_rx_pop", 32'(rx_pop), 32'd0);
      chk("rst_mem_din", 32'(mem_din), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_io_buffer_full", 32'(io_buffer_full), 32'd0);
      chk("rst_program_done", 32'(program_done), 32'd0);
      chk("rst_tx_overflow", 32'(tx_overflow), 32'd0);
      do_reset();

      // Table-driven single-cycle accesses
      for (int i = 0; i < 13; i++) begin
         drive(tv[i].a, tv[i].wr, tv[i].d);
         rx_valid = tv[i].rxv; rx_data = tv[i].rxd;
         #1;
         chk($sformatf("tv%0d_ram_we", i), 32'(ram_we), 32'(tv[i].e_we));
         chk($sformatf("tv%0d_rx_pop", i), 32'(rx_pop), 32'(tv[i].e_pop));
         chk($sformatf("tv%0d_mem_din", i), 32'(mem_din), 32'(tv[i].e_din));
         chk($sformatf("tv%0d_tx_valid", i), 32'(tx_valid), 32'(tv[i].e_txv));
         step(1'b0);
      end

      // Zero bytes are not transmitted
      do_reset();
      tx_ready = 1'b1;
      drive(32'h0003_0000, 1'b1, 8'h48); step(1'b0);
      drive(32'h8003_0000, 1'b1, 8'h00); step(1'b0);
      drive(32'h0003_0000, 1'b1, 8'h49); step(1'b0);
      drive(32'h0003_0008, 1'b0, 8'h00);
      repeat (6) step(1'b0);
      chk("txseq_len", 32'(txlog.size()), 32'd2);
      if (txlog.size() == 2) begin
         chk("txseq_b0", 32'(txlog[0]), 32'h48);
         chk("txseq_b1", 32'(txlog[1]), 32'h49);
      end

      // Fill to near-full and overflow with the sink stalled
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         drive(32'h0003_0000, 1'b1, 8'(i));
         step(1'b0);
         if (i == 5) chk("fill5_io_buffer_full", 32'(io_buffer_full), 32'd0);
         if (i == 6) chk("fill6_io_buffer_full", 32'(io_buffer_full), 32'd1);
         if (i == 8) chk("fill8_tx_overflow", 32'(tx_overflow), 32'd0);
         if (i == 9) chk("fill9_tx_overflow", 32'(tx_overflow), 32'd1);
      end
      chk("full_tx_data", 32'(tx_data), 32'h01);

      // Stop while full: terminator waits for space, then drains behind the data
      drive(32'h0003_0004, 1'b1, 8'hEE); step(1'b0);
      drive(32'h0003_0008, 1'b0, 8'h00);
      repeat (3) step(1'b0);
      chk("stop_wait_program_done", 32'(program_done), 32'd0);
      chk("stop_wait_tx_valid", 32'(tx_valid), 32'd1);
      tx_ready = 1'b1;
      txlog.delete();
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         step(1'b0);
         if (program_done) got = 1'b1;
      end
      chk("drain_program_done", 32'(got), 32'd1);
      chk("drain_len", 32'(txlog.size()), 32'd9);
      for (int i = 0; i < 9 && i < txlog.size(); i++)
         chk($sformatf("drain_b%0d", i), 32'(txlog[i]), (i < 8) ? 32'(i + 1) : 32'd0);
      repeat (2) step(1'b0);
      chk("done_sticky", 32'(program_done), 32'd1);
      chk("overflow_sticky", 32'(tx_overflow), 32'd1);

      // Counter snapshot coherence at 0x000001FF
      do_reset();
      repeat (32'h1FF) step(1'b0);
      drive(32'h0003_0004, 1'b0, 8'h00); step(1'b0);
      chk("clk_b0", 32'(mem_din), 32'hFF);
      drive(32'h0003_0005, 1'b0, 8'h00); step(1'b0);
      chk("clk_b1", 32'(mem_din), 32'h01);
      drive(32'h0003_0006, 1'b0, 8'h00); step(1'b0);
      chk("clk_b2", 32'(mem_din), 32'h00);
      drive(32'h0003_0007, 1'b0, 8'h00); step(1'b0);
      chk("clk_b3", 32'(mem_din), 32'h00);
      drive(32'h0003_0005, 1'b0, 8'h00); step(1'b0);
      chk("clk_b1_again", 32'(mem_din), 32'h01);

      // Reset in the middle of a read, with a full FIFO and pending terminator
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         drive(32'h0003_0000, 1'b1, 8'(8'h40 + i)); step(1'b0);
      end
      drive(32'h0003_0004, 1'b1, 8'h00); step(1'b0);
      drive(32'h0000_0010, 1'b0, 8'h00); step(1'b0);
      chk("pre_rst_mem_din", 32'(mem_din), 32'hA5);
      #1;
      rst_in = 1'b0;
      #1;
      chk("mid_rst_mem_din", 32'(mem_din), 32'h00);
      chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("mid_rst_io_buffer_full", 32'(io_buffer_full), 32'd0);
      do_reset();
      tx_ready = 1'b1;
      repeat (12) step(1'b0);
      chk("post_rst_tx_count", 32'(txlog.size()), 32'd0);
      chk("post_rst_program_done", 32'(program_done), 32'd0);

      // Randomized traffic against the reference model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rnd = $urandom();
         r   = int'($urandom_range(0, 15));
         if (r < 6) begin
            lo = 16'($urandom_range(0, 31));
            mem_a = {rnd[31:18], 2'($urandom_range(0, 2)), lo};
         end else if (r < 10 || r > 13) begin
            mem_a = {rnd[31:18], 18'h30000};
         end else if (r < 13) begin
            mem_a = {rnd[31:18], 18'h30004 + 18'($urandom_range(0, 3))};
         end else begin
            mem_a = {rnd[31:18], 18'h30000 + 18'($urandom_range(8, 255))};
         end
         mem_wr = 1'($urandom_range(0, 1));
         if (mem_wr && mem_a[17:0] == 18'h30004 && $urandom_range(0, 15) != 0) mem_wr = 1'b0;
         mem_dout = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom());
         tx_ready = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
         step(1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 Parameter TX_DEPTH, default 8, UART transmit FIFO depth in bytes (power of two, >= 4).
REQ-002 Parameter FULL_MARGIN, default 2, number of free TX entries at or below which io_buffer_full asserts.
REQ-003 clk_in  input  1  system clock; all state on rising edge.
REQ-004 rst_in  input  1  asynchronous, active-low reset.
REQ-005 mem_a  input  32  CPU byte address; only [17:0] decoded.
REQ-006 mem_dout  input  8  CPU write data.
REQ-007 mem_wr  input  1  1 = write, 0 = read; every cycle out of reset is a bus access.
REQ-008 mem_din  output  8  read data returned to CPU.
REQ-009 io_buffer_full  output  1  TX FIFO near full.
REQ-010 ram_a  output  17  synchronous RAM address (= mem_a[16:0]).
REQ-011 ram_wdata  output  8  RAM write data (= mem_dout).
REQ-012 ram_we  output  1  RAM write enable.
REQ-013 ram_rdata  input  8  RAM read data, valid one cycle after address.
REQ-014 rx_data  input  8  / rx_valid  input  1  UART receive byte held until rx_pop.
REQ-015 rx_pop  output  1  one-cycle pulse consuming rx_data.
REQ-016 tx_data  output  8  / tx_valid  output  1  / tx_ready  input  1  UART transmit handshake.
REQ-017 program_done  output  1  sticky: stop requested and its terminator drained.
REQ-018 tx_overflow  output  1  sticky: a TX byte was dropped.

Function
REQ-019 Decode: mem_a[17:16]==2'b11 is IO space, otherwise RAM space.
REQ-020 RAM write: ram_we = mem_wr in RAM space, combinational, same cycle; no wait.
REQ-021 Read latency: exactly one cycle; a source-select register captures {RAM, UART_IN, CLOCK, ZERO} and mem_din is driven from that source in the following cycle.
REQ-022 RAM read: mem_din = ram_rdata in the cycle after a RAM-space read.
REQ-023 0x30000 read: mem_din next cycle = rx_data if rx_valid else 0x00; rx_pop pulses in the access cycle only when rx_valid.
REQ-024 0x30000 write: mem_dout pushed to TX FIFO; mem_dout==0x00 ignored (no push).
REQ-025 Cycle counter: 32-bit, increments every cycle out of reset, wraps 0xFFFFFFFF -> 0, independent of bus activity.
REQ-026 0x30004..0x30007 read: byte mem_a[1:0] of a snapshot, little-endian; reading offset 0 loads snapshot with the current counter and returns byte 0 of that value; offsets 1-3 return the held snapshot.
REQ-027 0x30004 write: pushes 0x00 terminator to TX FIFO and sets stop_pending; if FIFO full, the terminator is held pending and pushed on the first cycle with space (not dropped).
REQ-028 program_done sets when stop_pending, terminator pushed, FIFO empty and tx_valid low; clears only on reset.
REQ-029 Other IO addresses: reads return 0x00, writes ignored.
REQ-030 TX FIFO: tx_valid = not empty, tx_data = head; pop when tx_valid && tx_ready; simultaneous push and pop when full is accepted (count unchanged).
REQ-031 Push to full FIFO without simultaneous pop: byte dropped, tx_overflow set.
REQ-032 io_buffer_full = (TX_DEPTH - count) <= FULL_MARGIN, combinational from registered count.
REQ-033 Pointers wrap modulo TX_DEPTH; count width log2(TX_DEPTH)+1.

Reset
REQ-034 On rst_in low (asynchronous): mem_din=0x00, source select ZERO, counter 0, snapshot 0, FIFO empty, tx_valid=0, rx_pop=0, ram_we=0, io_buffer_full=0, stop_pending=0, program_done=0, tx_overflow=0.
REQ-035 Reset mid-transfer discards FIFO contents and pending terminator; an in-flight read returns 0x00.
REQ-036 Release synchronized externally; first access is accepted on first rising edge after release.

Verification
REQ-037 Write 0xA5 to 0x00010, read 0x00010 -> ram_we pulse, mem_din=0xA5 exactly one cycle after read.
REQ-038 Write 0x48,0x00,0x49 to 0x30000, tx_ready=1 -> tx_data sequence 0x48,0x49 only.
REQ-039 tx_ready=0, TX_DEPTH=8: 6 writes -> io_buffer_full=1; 9th write -> tx_overflow=1, count 8.
REQ-040 Counter at 0x000001FF: read 0x30004..0x30007 over 4 cycles -> bytes 0xFF,0x01,0x00,0x00 (coherent snapshot).
REQ-041 FIFO full, write 0x30004, then tx_ready=1 -> all 8 bytes then 0x00 emitted, program_done=1 after drain.
REQ-042 rx_valid=1 rx_data=0x31, read 0x30000 -> rx_pop one cycle, mem_din=0x31 next; rx_valid=0 -> 0x00.
